// File: rtl/mmio_uart_responder_pkg.sv
// Shared constants for the MMIO UART responder: region select, register offsets
// and STATUS bit positions.
package mmio_uart_responder_pkg;

  localparam logic [3:0]  MMIO_REGION_DEFAULT = 4'h8;
  localparam int unsigned DWIDTH_DEFAULT      = 32;

  typedef enum logic [7:0] {
    OFF_STATUS    = 8'h00,
    OFF_RX_DATA   = 8'h04,
    OFF_TX_DATA   = 8'h08,
    OFF_CYCLE_CNT = 8'h10,
    OFF_INST_CNT  = 8'h14,
    OFF_CNT_RESET = 8'h18
  } mmio_off_e;

  localparam int unsigned STATUS_TX_EMPTY_BIT = 0;
  localparam int unsigned STATUS_RX_VALID_BIT = 1;

endpackage

// File: rtl/mmio_uart_responder_if.sv
// CPU load/store port plus UART receiver/transmitter ready/valid signals.
interface mmio_uart_responder_if #(
  parameter int unsigned DWIDTH = 32
);
  logic [31:0]       addr;
  logic [DWIDTH-1:0] wdata;
  logic [3:0]        wbe;
  logic              rd_en;
  logic [DWIDTH-1:0] rdata;
  logic              inst_retired;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output addr, wdata, wbe, rd_en, inst_retired, rx_data, rx_valid, tx_ready,
    input  rdata, rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  addr, wdata, wbe, rd_en, inst_retired, rx_data, rx_valid, tx_ready,
    output rdata, rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_uart_responder_counters.sv
// Free-running cycle counter and retired-instruction counter with a shared
// synchronous clear that overrides the same cycle's increments.
module mmio_counters #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              cycle_inc_i,
  input  logic              inst_inc_i,
  output logic [DWIDTH-1:0] cycle_cnt_o,
  output logic [DWIDTH-1:0] inst_cnt_o
);
  logic [DWIDTH-1:0] cycle_q, cycle_d;
  logic [DWIDTH-1:0] inst_q, inst_d;

  always_comb begin
    cycle_d = cycle_q + {{(DWIDTH-1){1'b0}}, cycle_inc_i};
    inst_d  = inst_q + {{(DWIDTH-1){1'b0}}, inst_inc_i};
    if (clr_i) begin
      cycle_d = '0;
      inst_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      inst_q  <= '0;
    end else begin
      cycle_q <= cycle_d;
      inst_q  <= inst_d;
    end
  end

  assign cycle_cnt_o = cycle_q;
  assign inst_cnt_o  = inst_q;
endmodule

// File: rtl/mmio_uart_responder.sv
// MMIO target for region addr[31:28]==MMIO_REGION: UART bridge, counters and a
// registered read port with one-cycle latency.
module mmio_uart_responder
  import mmio_uart_responder_pkg::*;
#(
  parameter logic [3:0]  MMIO_REGION = MMIO_REGION_DEFAULT,
  parameter int unsigned DWIDTH      = DWIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_uart_responder_if.slave  bus
);
  logic              hit, wr;
  logic [7:0]        off;
  logic [DWIDTH-1:0] rd_val;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_fire, tx_wr, cnt_clr;
  logic [DWIDTH-1:0] cycle_cnt, inst_cnt;
  logic              unused_bits;

  assign hit     = (bus.addr[31:28] == MMIO_REGION);
  assign off     = bus.addr[7:0];
  assign wr      = hit & (|bus.wbe);
  assign tx_fire = tx_valid_q & bus.tx_ready;
  assign tx_wr   = wr & bus.wbe[0] & (off == OFF_TX_DATA);
  assign cnt_clr = wr & (off == OFF_CNT_RESET);

  assign unused_bits = ^{bus.addr[27:8], bus.wdata[DWIDTH-1:8]};

  // Receiver pops on the same edge that captures RX_DATA into rdata.
  assign bus.rx_ready = !rst & bus.rd_en & hit & (off == OFF_RX_DATA);

  mmio_counters #(.DWIDTH(DWIDTH)) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (cnt_clr),
    .cycle_inc_i (1'b1),
    .inst_inc_i  (bus.inst_retired),
    .cycle_cnt_o (cycle_cnt),
    .inst_cnt_o  (inst_cnt)
  );

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_STATUS: begin
        rd_val[STATUS_RX_VALID_BIT] = bus.rx_valid;
        rd_val[STATUS_TX_EMPTY_BIT] = !tx_valid_q;
      end
      OFF_RX_DATA:   rd_val[7:0] = bus.rx_data;
      OFF_CYCLE_CNT: rd_val = cycle_cnt;
      OFF_INST_CNT:  rd_val = inst_cnt;
      default:       rd_val = '0;
    endcase
  end

  always_comb begin
    rdata_d    = rdata_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (bus.rd_en) rdata_d = hit ? rd_val : '0;
    // A fire frees the slot in the same cycle, so a coincident write still lands.
    if (tx_fire) tx_valid_d = 1'b0;
    if (tx_wr && (!tx_valid_q || tx_fire)) begin
      tx_valid_d = 1'b1;
      tx_data_d  = bus.wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      rdata_q    <= rdata_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_mmio_uart_responder.sv
// Scoreboard bench for mmio_uart_responder: directed scenarios then random traffic
// against a queue/counter reference model.
module tb_mmio_uart_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmio_uart_responder_if #(.DWIDTH(32)) bus();

  mmio_uart_responder #(.MMIO_REGION(4'h8), .DWIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  slot[$];
  logic [7:0]  last_tx = 8'h00;
  logic [31:0] m_cyc   = 32'h0;
  logic [31:0] m_inst  = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a[31:28] == 4'h8) begin
      case (a[7:0])
        8'h00: v = {30'h0, bus.rx_valid, (slot.size() == 0)};
        8'h04: v = {24'h0, bus.rx_data};
        8'h10: v = m_cyc;
        8'h14: v = m_inst;
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  // Reference model: one-deep holding slot plus "cycles/instructions since last clear".
  initial forever begin
    @(posedge clk);
    if (rst) begin
      slot.delete();
      last_tx = 8'h00;
      m_cyc   = 32'h0;
      m_inst  = 32'h0;
    end else begin
      if (slot.size() > 0 && bus.tx_ready) void'(slot.pop_front());
      if (bus.addr[31:28] == 4'h8 && bus.wbe[0] && bus.addr[7:0] == 8'h08 && slot.size() == 0) begin
        slot.push_back(bus.wdata[7:0]);
        last_tx = bus.wdata[7:0];
      end
      if (bus.addr[31:28] == 4'h8 && bus.wbe != 4'h0 && bus.addr[7:0] == 8'h18) begin
        m_cyc  = 32'h0;
        m_inst = 32'h0;
      end else begin
        m_cyc  = m_cyc + 32'd1;
        m_inst = m_inst + (bus.inst_retired ? 32'd1 : 32'd0);
      end
    end
  end

  // Monitor: pops the expected read value the cycle after each load and tracks TX outputs.
  initial forever begin
    logic rd;
    @(posedge clk);
    rd = bus.rd_en && !rst;
    #1;
    if (rd) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdata_unexpected: got 0x%08h with no expected entry", bus.rdata);
      end else begin
        check("rdata", bus.rdata, exp_q.pop_front());
      end
    end
    check("tx_valid", {31'h0, bus.tx_valid}, {31'h0, slot.size() > 0});
    check("tx_data", {24'h0, bus.tx_data}, {24'h0, last_tx});
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be, input logic rd);
    logic exp_rdy;
    bus.addr  = a;
    bus.wdata = wd;
    bus.wbe   = be;
    bus.rd_en = rd;
    if (rd && !rst) exp_q.push_back(ref_read(a));
    exp_rdy = !rst && rd && a[31:28] == 4'h8 && a[7:0] == 8'h04;
    #1;
    check("rx_ready", {31'h0, bus.rx_ready}, {31'h0, exp_rdy});
    @(negedge clk);
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  logic [7:0] offs [9];

  initial begin
    offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08; offs[3] = 8'h0C; offs[4] = 8'h10;
    offs[5] = 8'h14; offs[6] = 8'h18; offs[7] = 8'h20; offs[8] = 8'hFF;
    rst = 1'b1;
    bus.addr = '0; bus.wdata = '0; bus.wbe = '0; bus.rd_en = 1'b0;
    bus.inst_retired = 1'b0; bus.rx_data = '0; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    rst = 1'b0;

    drive(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    check("status_after_reset", bus.rdata, 32'h1);

    bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
    drive(32'h8000_0004, 32'h0, 4'h0, 1'b1);
    check("rx_data_read", bus.rdata, 32'h5A);
    idle();

    drive(32'h8000_0008, 32'h41, 4'b0001, 1'b0);
    check("tx_load", {23'h0, bus.tx_valid, bus.tx_data}, 32'h141);
    drive(32'h8000_0008, 32'h42, 4'b0001, 1'b0);
    check("tx_drop", {23'h0, bus.tx_valid, bus.tx_data}, 32'h141);
    bus.tx_ready = 1'b1;
    idle();
    check("tx_drain", {31'h0, bus.tx_valid}, 32'h0);
    bus.tx_ready = 1'b0;
    drive(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    check("status_tx_empty", bus.rdata, 32'h3);

    drive(32'h8000_0008, 32'h44, 4'b0001, 1'b0);
    bus.tx_ready = 1'b1;
    drive(32'h8000_0008, 32'h43, 4'b0001, 1'b0);
    check("tx_fire_and_load", {23'h0, bus.tx_valid, bus.tx_data}, 32'h143);
    bus.tx_ready = 1'b0;

    drive(32'h8000_0018, 32'hDEAD_BEEF, 4'b1000, 1'b0);
    for (int i = 0; i < 100; i++) begin
      bus.inst_retired = (i % 5) < 3;
      idle();
    end
    bus.inst_retired = 1'b0;
    drive(32'h8000_0010, 32'h0, 4'h0, 1'b1);
    check("cycle_cnt_100", bus.rdata, 32'd100);
    drive(32'h8000_0014, 32'h0, 4'h0, 1'b1);
    check("inst_cnt_60", bus.rdata, 32'd60);

    drive(32'h8000_0010, 32'h1234_5678, 4'hF, 1'b0);
    drive(32'h8000_0010, 32'h0, 4'h0, 1'b1);
    check("cnt_write_ignored", bus.rdata, 32'd103);

    force dut.u_cnt.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_cnt.cycle_q;
    m_cyc = 32'hFFFF_FFFF;
    drive(32'h8000_0010, 32'h0, 4'h0, 1'b1);
    check("cycle_pre_wrap", bus.rdata, 32'hFFFF_FFFF);
    drive(32'h8000_0010, 32'h0, 4'h0, 1'b1);
    check("cycle_wrap", bus.rdata, 32'h0);

    drive(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    drive(32'h8000_0020, 32'h0, 4'h0, 1'b1);
    check("unmapped_read", bus.rdata, 32'h0);
    drive(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    drive(32'h4000_0000, 32'h0, 4'h0, 1'b1);
    check("miss_read", bus.rdata, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [3:0]  be;
      a = $urandom;
      a[31:28] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h8;
      a[7:0]   = offs[$urandom_range(0, 8)];
      be = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      if (a[7:0] == 8'h18 && $urandom_range(0, 3) != 0) be = 4'h0;
      bus.rx_valid     = 1'($urandom);
      bus.rx_data      = 8'($urandom);
      bus.tx_ready     = ($urandom_range(0, 3) == 0);
      bus.inst_retired = 1'($urandom);
      drive(a, $urandom, be, 1'($urandom));
    end

    bus.inst_retired = 1'b0;
    repeat (3) idle();
    check("queue_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
